// File: rtl/ta_cap_sched.sv
// ta_cap_sched: frame-level capture trigger scheduler for the clk50 domain.
// Steps cap_phase through every phase of each frame, one trigger per phase,
// waits for the capture-ready handshake, inserts a settle gap between
// triggers and supervises each wait with a timeout.
module ta_cap_sched #(
    parameter int unsigned CAP0_1  = 2,
    parameter int unsigned FRM_W   = 16,
    parameter int unsigned GAP_CYC = 16,
    parameter int unsigned TMO_CYC = 500000,
    parameter int unsigned TMO_W   = 20
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [FRM_W-1:0]  frame_num,
    output logic              cap_trig,
    input  logic              capr_rdy,
    output logic [CAP0_1-1:0] cap_phase,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              tmo_err,
    output logic [FRM_W-1:0]  frm_cnt
);

    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [CAP0_1-1:0] PH_LAST  = '1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TRIG = 3'd1,
        S_WAIT = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [FRM_W-1:0]    frm_num_q, frm_num_d;
    logic [FRM_W-1:0]    frm_cnt_q, frm_cnt_d;
    logic [CAP0_1-1:0]   phase_q, phase_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                stop_pend_q, stop_pend_d;
    logic                aborted_q, aborted_d;
    logic                tmo_err_q, tmo_err_d;
    logic                cap_trig_q, cap_trig_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Next-state, counters and sticky flags; outputs follow the next state.
    always_comb begin
        state_d     = state_q;
        frm_num_d   = frm_num_q;
        frm_cnt_d   = frm_cnt_q;
        phase_d     = phase_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        stop_pend_d = stop_pend_q;
        aborted_d   = aborted_q;
        tmo_err_d   = tmo_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    aborted_d   = 1'b0;
                    tmo_err_d   = 1'b0;
                    stop_pend_d = 1'b0;
                    if (frame_num != '0) begin
                        frm_num_d = frame_num;
                        frm_cnt_d = '0;
                        phase_d   = '0;
                        state_d   = S_TRIG;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_TRIG: begin
                tmo_d = '0;
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // A stop here is remembered but the handshake still completes.
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (capr_rdy) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_err_d = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_GAP: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (gap_q == GAP_LAST) begin
                    // Position advances even when the run is being aborted.
                    phase_d = phase_q + CAP0_1'(1);
                    if (phase_q == PH_LAST) begin
                        frm_cnt_d = frm_cnt_q + FRM_W'(1);
                    end
                    if (stop_pend_q || stop) begin
                        aborted_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (frm_cnt_d == frm_num_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_TRIG;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            S_DONE: begin
                stop_pend_d = 1'b0;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        cap_trig_d = (state_d == S_TRIG);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            frm_num_q   <= '0;
            frm_cnt_q   <= '0;
            phase_q     <= '0;
            tmo_q       <= '0;
            gap_q       <= '0;
            stop_pend_q <= 1'b0;
            aborted_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            cap_trig_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frm_num_q   <= frm_num_d;
            frm_cnt_q   <= frm_cnt_d;
            phase_q     <= phase_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
            stop_pend_q <= stop_pend_d;
            aborted_q   <= aborted_d;
            tmo_err_q   <= tmo_err_d;
            cap_trig_q  <= cap_trig_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cap_trig  = cap_trig_q;
    assign cap_phase = phase_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign tmo_err   = tmo_err_q;
    assign frm_cnt   = frm_cnt_q;

endmodule

// File: tb/tb_ta_cap_sched.sv
// tb_ta_cap_sched: randomized run bench for ta_cap_sched against a
// run-level timing model (trigger times, final position and flags).
module tb_ta_cap_sched;

    localparam int unsigned CW  = 2;
    localparam int unsigned FW  = 16;
    localparam int          GAP = 16;
    localparam int          TMO = 100;
    localparam int unsigned TW  = 20;
    localparam int          NPH = 4;

    logic          clk50 = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          capr_rdy;
    logic [FW-1:0] frame_num;
    logic          cap_trig;
    logic [CW-1:0] cap_phase;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          tmo_err;
    logic [FW-1:0] frm_cnt;

    int n_chk     = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int trig_seen = 0;

    always #5 clk50 = ~clk50;

    ta_cap_sched #(
        .CAP0_1 (CW),
        .FRM_W  (FW),
        .GAP_CYC(GAP),
        .TMO_CYC(TMO),
        .TMO_W  (TW)
    ) dut (
        .clk50    (clk50),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .frame_num(frame_num),
        .cap_trig (cap_trig),
        .capr_rdy (capr_rdy),
        .cap_phase(cap_phase),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .tmo_err  (tmo_err),
        .frm_cnt  (frm_cnt)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance to the next falling edge; cycle index and trigger tally live here.
    task automatic step();
        @(negedge clk50);
        cyc++;
        if (cap_trig) trig_seen++;
    endtask

    task automatic check_zero(input string pre);
        check({pre, "_cap_trig"}, int'(cap_trig), 0);
        check({pre, "_busy"}, int'(busy), 0);
        check({pre, "_done"}, int'(done), 0);
        check({pre, "_aborted"}, int'(aborted), 0);
        check({pre, "_tmo_err"}, int'(tmo_err), 0);
        check({pre, "_frm_cnt"}, int'(frm_cnt), 0);
        check({pre, "_cap_phase"}, int'(cap_phase), 0);
    endtask

    task automatic wait_trig(output int t, output bit ok);
        ok = 1'b0;
        t  = cyc;
        for (int i = 0; i < 400; i++) begin
            if (cap_trig) begin
                ok = 1'b1;
                t  = cyc;
                return;
            end
            step();
        end
    endtask

    task automatic wait_done(output int t, output bit ok);
        ok = 1'b0;
        t  = cyc;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                ok = 1'b1;
                t  = cyc;
                return;
            end
            step();
        end
    endtask

    task automatic recover();
        rst = 1'b1; start = 1'b0; stop = 1'b0; capr_rdy = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    // One run. mode: 0 normal, 1 withhold capr_rdy at trigger kev,
    // 2 stop during WAIT of trigger kev, 3 reset during GAP of trigger kev.
    task automatic run(input int fn, input int mode, input int kev, input int sv_in,
                       input int fixed_d, input int edge_k, input bit force_inj);
        int s, t, t_exp, d, sv, n, base;
        int exp_trigs, exp_done, exp_frm, exp_ph, exp_ab, exp_tmo;
        bit ok, inj_busy, stray;
        n    = fn * NPH;
        base = trig_seen;
        frame_num = FW'(fn);
        start = 1'b1;
        s = cyc;
        step();
        start = 1'b0;
        frame_num = FW'($urandom);

        if (fn == 0) begin
            check("zero_done", int'(done), 1);
            check("zero_busy", int'(busy), 1);
            check("zero_aborted", int'(aborted), 0);
            check("zero_tmo_err", int'(tmo_err), 0);
            step();
            check("zero_done_after", int'(done), 0);
            check("zero_busy_after", int'(busy), 0);
            check("zero_trigs", trig_seen - base, 0);
            return;
        end

        t_exp = s + 1;
        exp_trigs = n; exp_frm = fn; exp_ph = 0; exp_ab = 0; exp_tmo = 0; exp_done = -1;
        for (int k = 0; k < n; k++) begin
            wait_trig(t, ok);
            check("trig_seen", int'(ok), 1);
            if (!ok) begin
                recover();
                return;
            end
            check("trig_time", t, t_exp);
            check("trig_phase", int'(cap_phase), k % NPH);
            if (mode == 1 && k == kev) begin
                exp_trigs = k + 1; exp_frm = k / NPH; exp_ph = k % NPH;
                exp_ab = 1; exp_tmo = 1;
                exp_done = t_exp + 1 + TMO;
                break;
            end
            if (fixed_d != 0) d = fixed_d;
            else if (k == edge_k) d = TMO;
            else d = int'($urandom_range(1, 20));
            sv = (sv_in > 0) ? sv_in : int'($urandom_range(1, d));
            if (sv > d) sv = d;
            inj_busy = force_inj ? 1'b1 : 1'($urandom_range(0, 1));
            stray    = force_inj ? 1'b1 : 1'($urandom_range(0, 1));
            for (int c = 1; c <= d; c++) begin
                step();
                stop     = (mode == 2 && k == kev && c == sv);
                capr_rdy = (c == d);
                start    = (inj_busy && c == 1);
                if (c == 1) frame_num = FW'(fn + 1);
            end
            step();
            stop = 1'b0; start = 1'b0; capr_rdy = stray;
            if (stray) begin
                step();
                capr_rdy = 1'b0;
            end
            if (mode == 3 && k == kev) begin
                step();
                step();
                rst = 1'b1;
                #1;
                check_zero("rst_mid");
                check("rst_trig_count", trig_seen - base, k + 1);
                step();
                rst = 1'b0;
                step();
                return;
            end
            if (mode == 2 && k == kev) begin
                exp_trigs = k + 1; exp_frm = (k + 1) / NPH; exp_ph = (k + 1) % NPH;
                exp_ab = 1;
                exp_done = t_exp + d + GAP + 1;
                break;
            end
            t_exp = t_exp + d + GAP + 1;
        end
        if (exp_done < 0) exp_done = t_exp;

        wait_done(t, ok);
        check("done_seen", int'(ok), 1);
        if (!ok) begin
            recover();
            return;
        end
        check("done_time", t, exp_done);
        check("done_busy", int'(busy), 1);
        check("done_aborted", int'(aborted), exp_ab);
        check("done_tmo_err", int'(tmo_err), exp_tmo);
        check("done_frm_cnt", int'(frm_cnt), exp_frm);
        check("done_phase", int'(cap_phase), exp_ph);
        step();
        check("done_pulse_len", int'(done), 0);
        check("busy_after_done", int'(busy), 0);
        check("trig_count", trig_seen - base, exp_trigs);
        step();
        step();
    endtask

    initial begin
        int fn, mode, kev;
        rst = 1'b1; start = 1'b0; stop = 1'b0; capr_rdy = 1'b0; frame_num = '0;
        step();
        step();
        check_zero("reset");
        rst = 1'b0;
        step();
        step();

        run(3, 0, 0, 0, 5, -1, 1'b0);    // full run, fixed response latency
        run(2, 1, 2, 0, 5, -1, 1'b0);    // timeout on third trigger
        run(0, 0, 0, 0, 0, -1, 1'b0);    // empty run clears sticky flags
        run(2, 2, 1, 2, 12, -1, 1'b0);   // stop in WAIT of phase 1
        run(1, 0, 0, 0, 0, 1, 1'b1);     // expiry-coincident capr_rdy, stray inputs
        run(2, 3, 5, 0, 0, -1, 1'b0);    // reset in GAP of frame 1
        run(1, 0, 0, 0, 0, -1, 1'b0);    // fresh run after reset

        for (int r = 0; r < 6; r++) begin
            fn   = int'($urandom_range(1, 3));
            mode = int'($urandom_range(0, 2));
            kev  = int'($urandom_range(0, fn * NPH - 1));
            run(fn, mode, kev, 0, 0, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
